// File: rtl/d_input_debouncer.sv
// Input conditioning ahead of the D_FF data pin: synchronises rawIn into clk,
// debounces it with a consecutive-sample counter, and emits edge pulses.
//
// state | meaning
// IDLE  | syncOut matches D, nothing being counted
// COUNT | syncOut differs from D, counting consecutive differing samples
module d_input_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic clk,
  input  logic syncReset,
  input  logic rawIn,
  output logic D,
  output logic risePulse,
  output logic fallPulse,
  output logic busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   differ;
  logic                   commit;

  always_ff @(posedge clk) begin
    if (syncReset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rawIn};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign differ   = (sync_out != D);

  // With a single required sample, the first differing sample in IDLE commits.
  assign commit = differ && ((state == COUNT) ? (cnt == CNT_LAST) : (DEBOUNCE_CYCLES == 1));

  always_ff @(posedge clk) begin
    if (syncReset) begin
      state     <= IDLE;
      cnt       <= '0;
      D         <= 1'b0;
      risePulse <= 1'b0;
      fallPulse <= 1'b0;
      busy      <= 1'b0;
    end else begin
      risePulse <= 1'b0;
      fallPulse <= 1'b0;
      if (commit) begin
        D         <= sync_out;
        state     <= IDLE;
        cnt       <= '0;
        busy      <= 1'b0;
        risePulse <= sync_out;
        fallPulse <= ~sync_out;
      end else if (!differ) begin
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else if (state == IDLE) begin
        state <= COUNT;
        cnt   <= CNT_WIDTH'(1);
        busy  <= 1'b1;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_d_input_debouncer.sv
// Scoreboarded bench for d_input_debouncer: three parameterisations share one
// stimulus stream and are checked against a sliding-window reference model.
module tb_d_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       raw;
  logic [2:0] d, rise, fall, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  d_input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) u0 (
    .clk(clk), .syncReset(rst), .rawIn(raw),
    .D(d[0]), .risePulse(rise[0]), .fallPulse(fall[0]), .busy(busy[0]));

  d_input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(3)) u1 (
    .clk(clk), .syncReset(rst), .rawIn(raw),
    .D(d[1]), .risePulse(rise[1]), .fallPulse(fall[1]), .busy(busy[1]));

  d_input_debouncer #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(7), .CNT_WIDTH(3)) u2 (
    .clk(clk), .syncReset(rst), .rawIn(raw),
    .D(d[2]), .risePulse(rise[2]), .fallPulse(fall[2]), .busy(busy[2]));

  function automatic int ss_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int dc_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  // Reference model: a delay line for the synchroniser, then D flips when the
  // last DEBOUNCE_CYCLES samples since reset all disagree with D.
  bit         md    [3];
  bit         chain [3][$];
  bit         win   [3][$];
  logic [3:0] exp_q [3][$];

  task automatic model_step(input int i);
    bit         s;
    bit         all_diff;
    logic [3:0] e;
    if (rst) begin
      chain[i].delete();
      repeat (ss_of(i)) chain[i].push_back(1'b0);
      win[i].delete();
      md[i] = 1'b0;
      e = 4'b0000;
    end else begin
      s = chain[i][chain[i].size()-1];
      chain[i].push_front(raw);
      void'(chain[i].pop_back());
      win[i].push_back(s);
      if (win[i].size() > dc_of(i)) void'(win[i].pop_front());
      all_diff = (win[i].size() == dc_of(i));
      for (int j = 0; j < win[i].size(); j++)
        if (win[i][j] == md[i]) all_diff = 1'b0;
      if (all_diff) begin
        md[i] = s;
        e = {s, s, ~s, 1'b0};
      end else begin
        e = {md[i], 1'b0, 1'b0, s != md[i]};
      end
    end
    exp_q[i].push_back(e);
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  logic [3:0] mon_exp, mon_act;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (exp_q[i].size() > 0) begin
        mon_exp = exp_q[i].pop_front();
        mon_act = {d[i], rise[i], fall[i], busy[i]};
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard dut%0d cycle %0d {D,rise,fall,busy} got %b expected %b",
                   i, cyc, mon_act, mon_exp);
        end
      end
    end
  end

  task automatic drive(input bit r, input bit v, input int n);
    repeat (n) begin
      rst = r;
      raw = v;
      @(negedge clk);
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, req);
    end
  endtask

  // Release reset with rawIn=1 and count edges until dut0 raises D.
  task automatic measure_rise(input string name);
    int n;
    n = 0;
    rst = 1'b0;
    raw = 1'b1;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      @(negedge clk);
      if (d[0]) n = k;
    end
    check({name, "_latency"}, n, 6);
    check({name, "_rise_at_commit"}, int'(rise[0]), 1);
    @(negedge clk);
    check({name, "_rise_one_cycle"}, int'(rise[0]), 0);
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    raw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_D", int'(d[0]), 0);
    check("reset_busy", int'(busy[0]), 0);
    measure_rise("reset_release");
    drive(0, 1, 20);
    drive(0, 0, 20);
    drive(0, 1, 20);
    drive(0, 0, 20);
    drive(0, 1, 3);
    drive(0, 0, 20);
    check("glitch_D", int'(d[0]), 0);
    check("glitch_busy", int'(busy[0]), 0);

    drive(0, 1, 4);
    drive(1, 1, 1);
    measure_rise("mid_count_reset");
    drive(0, 0, 20);

    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      drive(0, k[0], 1);
      pulses += int'(rise[0]) + int'(fall[0]) + int'(rise[2]) + int'(fall[2]);
    end
    check("storm_pulses", pulses, 0);
    check("storm_D0", int'(d[0]), 0);
    check("storm_D2", int'(d[2]), 0);

    repeat (300) begin
      if ($urandom_range(0, 39) == 0)
        drive(1, raw, $urandom_range(1, 3));
      else
        drive(0, 1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    drive(0, 0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/d_input_debouncer.md
Name: d_input_debouncer

Overview:
- Input conditioning stage that sits directly upstream of the D_FF data input.
- Synchronises an asynchronous raw signal (switch or pin) into the `clk` domain and debounces it with a consecutive-sample counter.
- Drives a clean level `D` into the flip-flop, plus one-cycle edge pulses for downstream control logic.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops; must be ≥2.
- DEBOUNCE_CYCLES, 4: consecutive post-sync samples that must differ from `D` before `D` changes; must be ≥1.
- CNT_WIDTH, 3: counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- syncReset  input  1  synchronous, active-high reset.
- rawIn  input  1  asynchronous raw input; no timing relation to `clk`.
- D  output  1  debounced level; feeds D_FF.D.
- risePulse  output  1  high for one cycle when `D` goes 0→1.
- fallPulse  output  1  high for one cycle when `D` goes 1→0.
- busy  output  1  high while a candidate change is being counted (state COUNT).

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - Reset is synchronous and active-high. It is sampled on the rising edge of `clk` and takes priority over all other logic.
  - Values after a reset edge: sync chain all 0, `D`=0, counter=0, state=IDLE, `risePulse`=0, `fallPulse`=0, `busy`=0.
- Synchroniser:
  - `rawIn` passes through a SYNC_STAGES flop shift chain.
  - `syncOut` is the last stage. Nothing else samples `rawIn` directly.
- Counter and FSM, evaluated each rising edge when `syncReset`=0:
  - IDLE:
    - If `syncOut`==`D`: stay in IDLE, counter=0.
    - If `syncOut`!=`D` and DEBOUNCE_CYCLES==1: commit immediately (see Commit).
    - If `syncOut`!=`D` otherwise: go to COUNT, counter=1.
  - COUNT:
    - If `syncOut`==`D`: go to IDLE, counter=0. This is a glitch rejection; outputs are unchanged.
    - If `syncOut`!=`D` and counter==DEBOUNCE_CYCLES−1: commit.
    - If `syncOut`!=`D` otherwise: counter+1, stay in COUNT.
  - Commit:
    - `D`<=`syncOut`, state<=IDLE, counter<=0.
    - Set `risePulse` (new `D`=1) or `fallPulse` (new `D`=0) for exactly the one cycle after the commit edge, i.e. coincident with the new `D` value.
- Pulse and busy outputs:
  - Pulses are registered and default to 0 every cycle they are not set.
  - `risePulse` and `fallPulse` are never high together.
  - `busy` is a registered output, high exactly while state==COUNT.
- Latency:
  - A `rawIn` change set up before edge k, then held stable, appears on `D` after edge k+SYNC_STAGES+DEBOUNCE_CYCLES−1.
  - With defaults this is edge k+5, i.e. `D` valid 6 edges after first capture.
- Boundary rules:
  - Glitch of fewer than DEBOUNCE_CYCLES samples at `syncOut`: `D` unchanged, no pulse.
  - Counter never exceeds DEBOUNCE_CYCLES−1 and never wraps.
  - Reset asserted mid-count: the count is discarded and all outputs return to reset values on that edge.
  - Reset asserted in the pulse cycle: the pulse drops on that edge.
  - `rawIn` held 1 through reset release: the sync chain refills, then a normal rise commit occurs and `risePulse` fires once (reset `D`=0 differs).
  - `rawIn` toggling every cycle: `D` never changes.
  - Sustained stable input: no repeated pulses.

Test Plan:
- Reset check: assert `syncReset` for 2 edges with `rawIn`=1 → `D`=0, `busy`=0, pulses 0 during reset. After release, `D`=1 exactly 6 edges later (defaults), `risePulse`=1 for exactly that one cycle.
- Clean rise/fall, defaults: `rawIn` 0→1 held 20 cycles, then 1→0 held 20 cycles → one `risePulse`, one `fallPulse`. `D` changes 6 edges after each transition. `busy` high for 3 cycles before each commit.
- Glitch rejection: from `D`=0, drive `rawIn`=1 for 3 cycles, then 0 → `D` stays 0, no pulse, `busy` returns to 0.
- Reset mid-count: `rawIn` 0→1, assert `syncReset` 4 edges later for 1 cycle, then keep `rawIn`=1 → counter restarts. `D` rises 6 edges after reset deassertion, with exactly one `risePulse`.
- Toggle storm: `rawIn` alternates every cycle for 50 cycles → `D` constant, zero pulses.
- Parameter sweep: DEBOUNCE_CYCLES=1 and =7 (CNT_WIDTH=3), SYNC_STAGES=3 → latency equals SYNC_STAGES+DEBOUNCE_CYCLES edges in every case; no counter overflow at 7.
